// File: rtl/jtag_pkg.sv
`default_nettype none
// ============================================================================
// Module      : jtag_pkg
// Description : TAP state encoding, instruction opcodes and IR capture value.
// Revision    : 1.0 - initial release
// ============================================================================
package jtag_pkg;

    typedef enum logic [3:0] {
        TAP_TLR      = 4'h0,
        TAP_RTI      = 4'h1,
        TAP_SEL_DR   = 4'h2,
        TAP_CAP_DR   = 4'h3,
        TAP_SHIFT_DR = 4'h4,
        TAP_EXIT1_DR = 4'h5,
        TAP_PAUSE_DR = 4'h6,
        TAP_EXIT2_DR = 4'h7,
        TAP_UPD_DR   = 4'h8,
        TAP_SEL_IR   = 4'h9,
        TAP_CAP_IR   = 4'hA,
        TAP_SHIFT_IR = 4'hB,
        TAP_EXIT1_IR = 4'hC,
        TAP_PAUSE_IR = 4'hD,
        TAP_EXIT2_IR = 4'hE,
        TAP_UPD_IR   = 4'hF
    } tap_state_e;

    typedef enum logic [2:0] {
        INSTR_BYPASS   = 3'd0,
        INSTR_IDCODE   = 3'd1,
        INSTR_SAMPLE   = 3'd2,
        INSTR_TESTSEL  = 3'd3,
        INSTR_SOCRESET = 3'd4
    } instr_e;

    localparam logic [3:0] c_op_idcode   = 4'b0001;
    localparam logic [3:0] c_op_sample   = 4'b0010;
    localparam logic [3:0] c_op_testsel  = 4'b0011;
    localparam logic [3:0] c_op_socreset = 4'b0100;
    localparam logic [3:0] c_op_bypass   = 4'b1111;

    localparam logic [1:0] c_ir_capture  = 2'b01;

endpackage
`default_nettype wire

// File: rtl/jtag_tap_fsm.sv
`default_nettype none
// ============================================================================
// Module      : jtag_tap_fsm
// Description : 16-state TAP controller with decoded per-state action strobes.
// Revision    : 1.0 - initial release
// ============================================================================
module jtag_tap_fsm
    import jtag_pkg::*;
(
    input  logic       TCK,
    input  logic       TRST,
    input  logic       TMS,
    output tap_state_e state,
    output logic       capture_dr,
    output logic       shift_dr,
    output logic       update_dr,
    output logic       capture_ir,
    output logic       shift_ir,
    output logic       update_ir,
    output logic       tlr
);

    tap_state_e r_state;
    tap_state_e w_next_state;

    always_ff @(posedge TCK or posedge TRST) begin
        if (TRST) begin
            r_state <= TAP_TLR;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            TAP_TLR:      w_next_state = TMS ? TAP_TLR      : TAP_RTI;
            TAP_RTI:      w_next_state = TMS ? TAP_SEL_DR   : TAP_RTI;
            TAP_SEL_DR:   w_next_state = TMS ? TAP_SEL_IR   : TAP_CAP_DR;
            TAP_CAP_DR:   w_next_state = TMS ? TAP_EXIT1_DR : TAP_SHIFT_DR;
            TAP_SHIFT_DR: w_next_state = TMS ? TAP_EXIT1_DR : TAP_SHIFT_DR;
            TAP_EXIT1_DR: w_next_state = TMS ? TAP_UPD_DR   : TAP_PAUSE_DR;
            TAP_PAUSE_DR: w_next_state = TMS ? TAP_EXIT2_DR : TAP_PAUSE_DR;
            TAP_EXIT2_DR: w_next_state = TMS ? TAP_UPD_DR   : TAP_SHIFT_DR;
            TAP_UPD_DR:   w_next_state = TMS ? TAP_SEL_DR   : TAP_RTI;
            TAP_SEL_IR:   w_next_state = TMS ? TAP_TLR      : TAP_CAP_IR;
            TAP_CAP_IR:   w_next_state = TMS ? TAP_EXIT1_IR : TAP_SHIFT_IR;
            TAP_SHIFT_IR: w_next_state = TMS ? TAP_EXIT1_IR : TAP_SHIFT_IR;
            TAP_EXIT1_IR: w_next_state = TMS ? TAP_UPD_IR   : TAP_PAUSE_IR;
            TAP_PAUSE_IR: w_next_state = TMS ? TAP_EXIT2_IR : TAP_PAUSE_IR;
            TAP_EXIT2_IR: w_next_state = TMS ? TAP_UPD_IR   : TAP_SHIFT_IR;
            TAP_UPD_IR:   w_next_state = TMS ? TAP_SEL_DR   : TAP_RTI;
            default:      w_next_state = TAP_TLR;
        endcase
    end

    // Strobes qualify the rising edge that leaves the named state; tlr fires
    // on the edge that enters (or stays in) Test-Logic-Reset.
    assign state      = r_state;
    assign capture_dr = (r_state == TAP_CAP_DR);
    assign shift_dr   = (r_state == TAP_SHIFT_DR);
    assign update_dr  = (r_state == TAP_UPD_DR);
    assign capture_ir = (r_state == TAP_CAP_IR);
    assign shift_ir   = (r_state == TAP_SHIFT_IR);
    assign update_ir  = (r_state == TAP_UPD_IR);
    assign tlr        = (w_next_state == TAP_TLR);

endmodule
`default_nettype wire

// File: rtl/jtag_tap_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : jtag_tap_ctrl
// Description : JTAG TAP with IR, BYPASS/IDCODE/SAMPLE/TESTSEL/SOCRESET DRs.
// Revision    : 1.0 - initial release
// ============================================================================
module jtag_tap_ctrl
    import jtag_pkg::*;
#(
    parameter int          WIDTH      = 32,
    parameter int          IR_WIDTH   = 4,
    parameter int          TSEL_WIDTH = 2,
    parameter logic [31:0] IDCODE_VAL = 32'h1000_0001
) (
    input  logic                  TCK,
    input  logic                  TRST,
    input  logic                  TMS,
    input  logic                  TDI,
    output logic                  TDO,
    output logic                  TDO_EN,
    input  logic [WIDTH-1:0]      socOutput,
    output logic                  socCLK,
    output logic                  socRST,
    output logic [TSEL_WIDTH-1:0] socTestSel
);

    localparam logic [IR_WIDTH-1:0] c_ir_reset = IR_WIDTH'(c_op_idcode);

    tap_state_e w_state;
    logic       w_capture_dr, w_shift_dr, w_update_dr;
    logic       w_capture_ir, w_shift_ir, w_update_ir, w_tlr;

    logic [IR_WIDTH-1:0]   r_ir;
    logic [IR_WIDTH-1:0]   r_ir_sr;
    logic                  r_bypass_sr;
    logic [31:0]           r_id_sr;
    logic [WIDTH-1:0]      r_sample_sr;
    logic [TSEL_WIDTH-1:0] r_tsel_sr;
    logic                  r_rst_sr;
    logic [TSEL_WIDTH-1:0] r_tsel;
    logic                  r_soc_rst;
    instr_e                w_instr;
    logic                  w_tdo;

    jtag_tap_fsm u_fsm (
        .TCK        (TCK),
        .TRST       (TRST),
        .TMS        (TMS),
        .state      (w_state),
        .capture_dr (w_capture_dr),
        .shift_dr   (w_shift_dr),
        .update_dr  (w_update_dr),
        .capture_ir (w_capture_ir),
        .shift_ir   (w_shift_ir),
        .update_ir  (w_update_ir),
        .tlr        (w_tlr)
    );

    // Unrecognised opcodes fall through to BYPASS.
    always_comb begin
        w_instr = INSTR_BYPASS;
        if (r_ir == IR_WIDTH'(c_op_idcode)) begin
            w_instr = INSTR_IDCODE;
        end else if (r_ir == IR_WIDTH'(c_op_sample)) begin
            w_instr = INSTR_SAMPLE;
        end else if (r_ir == IR_WIDTH'(c_op_testsel)) begin
            w_instr = INSTR_TESTSEL;
        end else if (r_ir == IR_WIDTH'(c_op_socreset)) begin
            w_instr = INSTR_SOCRESET;
        end
    end

    always_ff @(posedge TCK or posedge TRST) begin
        if (TRST) begin
            r_ir    <= c_ir_reset;
            r_ir_sr <= '0;
        end else begin
            if (w_tlr) begin
                r_ir <= c_ir_reset;
            end else if (w_update_ir) begin
                r_ir <= r_ir_sr;
            end
            if (w_capture_ir) begin
                r_ir_sr <= IR_WIDTH'(c_ir_capture);
            end else if (w_shift_ir) begin
                r_ir_sr <= IR_WIDTH'({TDI, r_ir_sr} >> 1);
            end
        end
    end

    // Every DR shifts right with TDI entering at its own MSB.
    always_ff @(posedge TCK or posedge TRST) begin
        if (TRST) begin
            r_bypass_sr <= 1'b0;
            r_id_sr     <= '0;
            r_sample_sr <= '0;
            r_tsel_sr   <= '0;
            r_rst_sr    <= 1'b0;
        end else if (w_capture_dr) begin
            case (w_instr)
                INSTR_IDCODE:   r_id_sr     <= IDCODE_VAL;
                INSTR_SAMPLE:   r_sample_sr <= socOutput;
                INSTR_TESTSEL:  r_tsel_sr   <= r_tsel;
                INSTR_SOCRESET: r_rst_sr    <= r_soc_rst;
                default:        r_bypass_sr <= 1'b0;
            endcase
        end else if (w_shift_dr) begin
            case (w_instr)
                INSTR_IDCODE:   r_id_sr     <= 32'({TDI, r_id_sr} >> 1);
                INSTR_SAMPLE:   r_sample_sr <= WIDTH'({TDI, r_sample_sr} >> 1);
                INSTR_TESTSEL:  r_tsel_sr   <= TSEL_WIDTH'({TDI, r_tsel_sr} >> 1);
                INSTR_SOCRESET: r_rst_sr    <= TDI;
                default:        r_bypass_sr <= TDI;
            endcase
        end
    end

    always_ff @(posedge TCK or posedge TRST) begin
        if (TRST) begin
            r_tsel    <= '0;
            r_soc_rst <= 1'b0;
        end else if (w_tlr) begin
            r_tsel    <= '0;
            r_soc_rst <= 1'b0;
        end else if (w_update_dr) begin
            if (w_instr == INSTR_TESTSEL) begin
                r_tsel <= r_tsel_sr;
            end
            if (w_instr == INSTR_SOCRESET) begin
                r_soc_rst <= r_rst_sr;
            end
        end
    end

    always_comb begin
        w_tdo = 1'b0;
        if (w_shift_ir) begin
            w_tdo = r_ir_sr[0];
        end else if (w_shift_dr) begin
            case (w_instr)
                INSTR_IDCODE:   w_tdo = r_id_sr[0];
                INSTR_SAMPLE:   w_tdo = r_sample_sr[0];
                INSTR_TESTSEL:  w_tdo = r_tsel_sr[0];
                INSTR_SOCRESET: w_tdo = r_rst_sr;
                default:        w_tdo = r_bypass_sr;
            endcase
        end
    end

    assign TDO        = w_tdo;
    assign TDO_EN     = w_shift_dr | w_shift_ir;
    assign socCLK     = TCK;
    assign socRST     = TRST | r_soc_rst;
    assign socTestSel = r_tsel;

endmodule
`default_nettype wire

// File: tb/tb_jtag_tap_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_jtag_tap_ctrl
// Description : Directed self-checking bench for jtag_tap_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_jtag_tap_ctrl;
    import jtag_pkg::*;

    localparam logic [31:0] c_idcode = 32'h1000_0001;

    logic        TCK = 1'b0;
    logic        TRST;
    logic        TMS;
    logic        TDI;
    logic        TDO;
    logic        TDO_EN;
    logic [31:0] socOutput;
    logic        socCLK;
    logic        socRST;
    logic [1:0]  socTestSel;

    int checks   = 0;
    int failures = 0;
    logic sbq[$];

    jtag_tap_ctrl #(
        .WIDTH      (32),
        .IR_WIDTH   (4),
        .TSEL_WIDTH (2),
        .IDCODE_VAL (c_idcode)
    ) dut (
        .TCK        (TCK),
        .TRST       (TRST),
        .TMS        (TMS),
        .TDI        (TDI),
        .TDO        (TDO),
        .TDO_EN     (TDO_EN),
        .socOutput  (socOutput),
        .socCLK     (socCLK),
        .socRST     (socRST),
        .socTestSel (socTestSel)
    );

    always #5 TCK = ~TCK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic tms, input logic tdi);
        TMS = tms;
        TDI = tdi;
        @(posedge TCK);
        #1;
    endtask

    task automatic push_bits(input logic [31:0] w, input int n);
        for (int i = 0; i < n; i++) sbq.push_back(w[i]);
    endtask

    // Compares TDO against the scoreboard before each shifting edge.
    task automatic shift_bits(input int n, input logic [31:0] din, input bit exit_last);
        logic e;
        for (int i = 0; i < n; i++) begin
            e = (sbq.size() > 0) ? sbq.pop_front() : 1'bx;
            chk($sformatf("tdo[%0d]", i), {31'd0, TDO}, {31'd0, e});
            chk($sformatf("tdo_en[%0d]", i), {31'd0, TDO_EN}, 32'd1);
            step(exit_last && (i == n - 1), din[i]);
        end
    endtask

    task automatic finish_scan();
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
    endtask

    task automatic to_shift_dr();
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        chk("cap_dr_tdo_en", {31'd0, TDO_EN}, 32'd0);
        step(1'b0, 1'b0);
    endtask

    task automatic load_ir(input logic [3:0] op);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        push_bits(32'h1, 4);
        shift_bits(4, {28'd0, op}, 1'b1);
        finish_scan();
        chk("ir_loaded", {28'd0, dut.r_ir}, {28'd0, op});
    endtask

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        TRST = 1'b1; TMS = 1'b0; TDI = 1'b0; socOutput = '0;
        repeat (3) @(posedge TCK);
        #1;
        chk("rst_state", 32'(dut.w_state), 32'(TAP_TLR));
        chk("rst_ir", {28'd0, dut.r_ir}, 32'h1);
        chk("rst_tsel", {30'd0, socTestSel}, 32'd0);
        chk("rst_socrst_hi", {31'd0, socRST}, 32'd1);
        chk("rst_tdo_en", {31'd0, TDO_EN}, 32'd0);
        @(negedge TCK);
        TRST = 1'b0;
        #1;
        chk("socrst_released", {31'd0, socRST}, 32'd0);

        // TMS-only reset from SHIFT_DR
        step(1'b0, 1'b0);
        to_shift_dr();
        chk("in_shift_dr", 32'(dut.w_state), 32'(TAP_SHIFT_DR));
        repeat (5) step(1'b1, 1'b0);
        chk("tms_reset_state", 32'(dut.w_state), 32'(TAP_TLR));
        chk("tms_reset_ir", {28'd0, dut.r_ir}, 32'h1);

        // IDCODE read, TDO_EN exactly for the 32 shift cycles
        step(1'b0, 1'b0);
        to_shift_dr();
        push_bits(c_idcode, 32);
        shift_bits(32, 32'd0, 1'b1);
        chk("idcode_exit_tdo_en", {31'd0, TDO_EN}, 32'd0);
        finish_scan();

        // BYPASS and an undefined opcode: TDO is TDI delayed one edge
        load_ir(4'b1111);
        to_shift_dr();
        push_bits(32'b1010, 4);
        shift_bits(4, 32'b1101, 1'b1);
        finish_scan();
        load_ir(4'b1010);
        to_shift_dr();
        push_bits(32'b1010, 4);
        shift_bits(4, 32'b1101, 1'b1);
        finish_scan();

        // SAMPLE
        socOutput = 32'hDEAD_BEEF;
        load_ir(4'b0010);
        to_shift_dr();
        push_bits(32'hDEAD_BEEF, 32);
        shift_bits(32, 32'd0, 1'b1);
        finish_scan();

        // TESTSEL write then readback
        load_ir(4'b0011);
        to_shift_dr();
        push_bits(32'b00, 2);
        shift_bits(2, 32'b10, 1'b1);
        finish_scan();
        chk("tsel_updated", {30'd0, socTestSel}, 32'b10);
        to_shift_dr();
        push_bits(32'b10, 2);
        shift_bits(2, 32'b10, 1'b1);
        finish_scan();
        chk("tsel_hold", {30'd0, socTestSel}, 32'b10);

        // SOCRESET, then cleared by TMS reset
        load_ir(4'b0100);
        to_shift_dr();
        push_bits(32'b0, 1);
        shift_bits(1, 32'b1, 1'b1);
        finish_scan();
        chk("socrst_set", {31'd0, socRST}, 32'd1);
        repeat (5) step(1'b1, 1'b0);
        chk("tlr2_state", 32'(dut.w_state), 32'(TAP_TLR));
        chk("tlr2_socrst", {31'd0, socRST}, 32'd0);
        chk("tlr2_tsel", {30'd0, socTestSel}, 32'd0);
        chk("tlr2_ir", {28'd0, dut.r_ir}, 32'h1);

        // TRST mid-shift of IDCODE at bit 10
        step(1'b0, 1'b0);
        to_shift_dr();
        push_bits(c_idcode, 32);
        shift_bits(10, 32'd0, 1'b0);
        #1 TRST = 1'b1;
        #1;
        chk("trst_tdo", {31'd0, TDO}, 32'd0);
        chk("trst_tdo_en", {31'd0, TDO_EN}, 32'd0);
        chk("trst_state", 32'(dut.w_state), 32'(TAP_TLR));
        sbq.delete();
        #1 TRST = 1'b0;

        // Full IDCODE again, split by a PAUSE_DR excursion
        step(1'b0, 1'b0);
        to_shift_dr();
        push_bits(c_idcode, 32);
        shift_bits(16, 32'd0, 1'b1);
        step(1'b0, 1'b0);
        chk("pause_state", 32'(dut.w_state), 32'(TAP_PAUSE_DR));
        chk("pause_tdo_en", {31'd0, TDO_EN}, 32'd0);
        step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        shift_bits(16, 32'd0, 1'b1);
        finish_scan();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
